// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: icodes, status codes,
// register ids, access-FSM states and memory-op classifiers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_mem_read(input logic [3:0] icode);
    case (icode)
      I_MRMOVQ, I_RET, I_POPQ: is_mem_read = 1'b1;
      default:                 is_mem_read = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: is_mem_write = 1'b1;
      default:                   is_mem_write = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_dmem.sv
// Word-addressed data memory with asynchronous array read followed by a
// (LAT-1)-stage register pipeline, so read data is valid in the LAT-th cycle.
module y86_dmem #(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 1,
  parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // Storage array write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  if (LAT == 1) begin : g_rd_direct
    assign rdata_o = mem_q[idx_i];
  end else begin : g_rd_pipe
    logic [DATA_W-1:0] pipe_q [LAT-1];

    // Read pipeline; the address is held stable upstream for the whole access.
    always_ff @(posedge clk) begin
      pipe_q[0] <= mem_q[idx_i];
      for (int i = 1; i < LAT - 1; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign rdata_o = pipe_q[LAT-2];
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Y86-64 memory stage with LAT-cycle data memory and W pipeline register.
// Optional MEMSTAGE_ALIGN_CHK_EN: misaligned addresses report SADR.
module mem_stage_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_valid,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic              m_stall,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_stat,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM
);

  localparam int                IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(MEM_WORDS * 8);
  localparam logic [2:0]        CNT_LAST   = 3'(LAT - 1);

  mem_state_e        state_q;
  logic [2:0]        cnt_q;
  logic [3:0]        w_stat_q, w_icode_q, w_dste_q, w_dstm_q;
  logic [DATA_W-1:0] w_vale_q, w_valm_q;

  logic [3:0]        w_stat_d, w_icode_d, w_dste_d, w_dstm_d;
  logic [DATA_W-1:0] w_vale_d, w_valm_d;

  logic [DATA_W-1:0] mem_addr_s, rdata_s, m_valm_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [3:0]        m_stat_s;
  logic              is_rd_s, is_wr_s, is_mem_s, misalign_s, addr_err_s;
  logic              frozen_s, mem_go_s, last_s, stall_s, we_s;

`ifdef MEMSTAGE_ALIGN_CHK_EN
  assign misalign_s = (mem_addr_s[2:0] != 3'b000);
`else
  assign misalign_s = 1'b0;
`endif

  assign mem_idx_s = mem_addr_s[IDX_W+2:3];

  // Decode the memory op, its address, status and access-cycle control.
  always_comb begin
    is_rd_s  = is_mem_read(M_icode);
    is_wr_s  = is_mem_write(M_icode);
    is_mem_s = is_rd_s | is_wr_s;
    case (M_icode)
      I_RET, I_POPQ: mem_addr_s = M_valA;
      default:       mem_addr_s = M_valE;
    endcase
    addr_err_s = is_mem_s & ((mem_addr_s >= ADDR_LIMIT) | misalign_s);
    if (M_stat != S_AOK) begin
      m_stat_s = M_stat;
    end else if (addr_err_s) begin
      m_stat_s = S_ADR;
    end else begin
      m_stat_s = S_AOK;
    end
    frozen_s = (w_stat_q != S_AOK);
    mem_go_s = M_valid & ~frozen_s & is_mem_s & (M_stat == S_AOK) & ~addr_err_s;
    if (LAT == 1) begin
      last_s = 1'b1;
    end else begin
      last_s = (state_q == ST_ACCESS) && (cnt_q == CNT_LAST);
    end
    stall_s = mem_go_s & ~last_s;
    // Writes land only on the final access edge and never while in reset.
    we_s = mem_go_s & last_s & is_wr_s & ~rst;
    if (is_rd_s) begin
      m_valm_s = rdata_s;
    end else begin
      m_valm_s = {DATA_W{1'b0}};
    end
  end

  // Next W contents: a bubble while stalling or when M is empty.
  always_comb begin
    if (!M_valid || stall_s) begin
      w_stat_d  = S_AOK;
      w_icode_d = I_NOP;
      w_vale_d  = {DATA_W{1'b0}};
      w_valm_d  = {DATA_W{1'b0}};
      w_dste_d  = RNONE;
      w_dstm_d  = RNONE;
    end else begin
      if ((M_icode == I_HALT) && (m_stat_s == S_AOK)) begin
        w_stat_d = S_HLT;
      end else begin
        w_stat_d = m_stat_s;
      end
      w_icode_d = M_icode;
      w_vale_d  = M_valE;
      w_valm_d  = m_valm_s;
      w_dste_d  = M_dstE;
      w_dstm_d  = M_dstM;
    end
  end

  // Access FSM and W register; a non-AOK W freezes everything until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      w_stat_q  <= S_AOK;
      w_icode_q <= I_NOP;
      w_vale_q  <= {DATA_W{1'b0}};
      w_valm_q  <= {DATA_W{1'b0}};
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
    end else if (frozen_s) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
      case (state_q)
        ST_IDLE: begin
          if (stall_s) begin
            state_q <= ST_ACCESS;
            cnt_q   <= 3'd1;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end
        end
        ST_ACCESS: begin
          if (stall_s) begin
            state_q <= ST_ACCESS;
            cnt_q   <= cnt_q + 3'd1;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  y86_dmem #(
    .DATA_W   (DATA_W),
    .MEM_WORDS(MEM_WORDS),
    .LAT      (LAT),
    .IDX_W    (IDX_W)
  ) u_dmem (
    .clk    (clk),
    .we_i   (we_s),
    .idx_i  (mem_idx_s),
    .wdata_i(M_valA),
    .rdata_o(rdata_s)
  );

  assign m_stall = stall_s & ~rst;
  assign m_valM  = m_valm_s;
  assign m_stat  = m_stat_s;
  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_valE  = w_vale_q;
  assign W_valM  = w_valm_q;
  assign W_dstE  = w_dste_q;
  assign W_dstM  = w_dstm_q;

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter DATA_W, 64, data and address width.
REQ-003 SHALL have parameter MEM_WORDS, 1024, data memory depth in DATA_W words.
REQ-004 SHALL have parameter LAT, 1, memory access latency in cycles, legal 1..4.
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port M_valid  in  1  M register holds a real instruction.
REQ-008 SHALL have ports M_stat/M_icode  in  4/4  status and icode from execute.
REQ-009 SHALL have ports M_valE/M_valA  in  DATA_W/DATA_W  ALU result and operand A.
REQ-010 SHALL have ports M_dstE/M_dstM  in  4/4  destination registers (0xF = none).
REQ-011 SHALL have port m_stall  out  1  upstream must hold all M_* stable.
REQ-012 SHALL have ports m_valM/m_stat  out  DATA_W/4  current-cycle read data and status.
REQ-013 SHALL have ports W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  4/4/DATA_W/DATA_W/4/4  write-back register.

Function
REQ-014 SHALL treat icodes as reads: 5 (mrmovq), 9 (ret), B (popq); writes: 4 (rmmovq), 8 (call), A (pushq).
REQ-015 SHALL use address M_valE for 4, 5, 8, A and address M_valA for 9, B; write data is M_valA.
REQ-016 SHALL index memory by addr>>3; addr >= MEM_WORDS*8 SHALL yield m_stat = SADR(3) and suppress the write.
REQ-017 SHALL pass non-memory instructions to W at the next edge with m_stall = 0.
REQ-018 SHALL implement FSM IDLE -> ACCESS -> IDLE; for LAT > 1 an accepted memory op SHALL enter ACCESS with m_stall = 1 for LAT-1 cycles.
REQ-019 SHALL update W at the edge ending the LAT-th cycle; during stall cycles W SHALL load a bubble (icode 1, stat SAOK, dstE/dstM 0xF).
REQ-020 SHALL commit a write only at the final access edge; a read issued immediately after a write to the same address SHALL return the new data.
REQ-021 SHALL set m_stat = M_stat when M_stat != SAOK(1), else SADR on a bad address, else SAOK; icode 0 with SAOK SHALL give W_stat = SHLT(2).
REQ-022 SHALL suppress memory writes when M_stat != SAOK.
REQ-023 SHALL, once W_stat != SAOK, freeze W, hold m_stall = 0, and ignore further inputs until reset.
REQ-024 SHALL load a bubble into W when M_valid = 0.

Reset
REQ-025 SHALL set, on rst: FSM IDLE, m_stall 0, W_stat SAOK, W_icode 1, W_valE/W_valM 0, W_dstE/W_dstM 0xF; memory contents are not reset.
REQ-026 SHALL drop an in-flight access on rst mid-ACCESS without committing its write.

Configuration
REQ-027 SHALL honour MEMSTAGE_ALIGN_CHK_EN: defined -> addr[2:0] != 0 gives SADR and suppresses access; undefined -> addr[2:0] ignored.

Structure
REQ-028 SHALL take icode constants, stat codes (SAOK/SHLT/SADR/SINS) and RNONE from shared package y86_pkg.
REQ-029 SHALL place the storage array plus LAT-deep read pipeline in sub-module y86_dmem.

Verification
REQ-030 SHALL test LAT=1: rmmovq (4) writes 0x1234 to 0x40, next mrmovq (5) from 0x40 -> W_valM = 0x1234, m_stall never 1.
REQ-031 SHALL test LAT=3: mrmovq -> m_stall high 2 cycles, two W bubbles, then W_icode = 5 with correct W_valM.
REQ-032 SHALL test a write to addr MEM_WORDS*8 -> W_stat = 3, later read of 0 unchanged, W frozen afterwards.
REQ-033 SHALL test icode 0 with SAOK -> W_stat = 2, and subsequent M_valid pulses not altering W.
REQ-034 SHALL test rst asserted in the 2nd cycle of a LAT=3 write -> W at reset values, target word unchanged.
REQ-035 SHALL test with MEMSTAGE_ALIGN_CHK_EN: rmmovq to 0x43 -> SADR; without the macro -> write lands at word 8.
